// File: rtl/alu_pkg.sv
// Shared definitions for the bit-sliced sequential 74181-style ALU:
// function-select codes, mode encodings and FSM states.
package alu_pkg;

    localparam logic [3:0] S_A            = 4'd0;
    localparam logic [3:0] S_AORB         = 4'd1;
    localparam logic [3:0] S_AORNB        = 4'd2;
    localparam logic [3:0] S_MINUS1       = 4'd3;
    localparam logic [3:0] S_APLUSANB     = 4'd4;
    localparam logic [3:0] S_AORBPLUSANB  = 4'd5;
    localparam logic [3:0] S_AMINUSBM1    = 4'd6;
    localparam logic [3:0] S_ANBMINUS1    = 4'd7;
    localparam logic [3:0] S_APLUSAB      = 4'd8;
    localparam logic [3:0] S_APLUSB       = 4'd9;
    localparam logic [3:0] S_AORNBPLUSAB  = 4'd10;
    localparam logic [3:0] S_ABMINUS1     = 4'd11;
    localparam logic [3:0] S_APLUSA       = 4'd12;
    localparam logic [3:0] S_AORBPLUSA    = 4'd13;
    localparam logic [3:0] S_AORNBPLUSA   = 4'd14;
    localparam logic [3:0] S_AMINUS1      = 4'd15;

    localparam logic M_LOGIC = 1'b1;
    localparam logic M_ARITH = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_slice4.sv
// Combinational 4-bit 74181-style slice. Arithmetic is X + Y + c_in with X/Y chosen by s;
// p means a carry-in would ripple straight through (X+Y == 15), g means X+Y alone carries.
module alu_slice4
    import alu_pkg::*;
(
    input  logic [3:0] a4,
    input  logic [3:0] b4,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       c_in,
    output logic [3:0] f4,
    output logic       c_out,
    output logic       c_msb_in,
    output logic       p,
    output logic       g
);

    logic [3:0] x_s;
    logic [3:0] y_s;
    logic [3:0] lf_s;
    logic [4:0] xy_s;
    logic [4:0] sum_s;
    logic [3:0] low_s;

    // Arithmetic operand pair selected by the function code
    always_comb begin
        x_s = a4;
        y_s = 4'h0;
        case (s)
            S_A:           begin x_s = a4;        y_s = 4'h0;      end
            S_AORB:        begin x_s = a4 | b4;   y_s = 4'h0;      end
            S_AORNB:       begin x_s = a4 | ~b4;  y_s = 4'h0;      end
            S_MINUS1:      begin x_s = 4'hF;      y_s = 4'h0;      end
            S_APLUSANB:    begin x_s = a4;        y_s = a4 & ~b4;  end
            S_AORBPLUSANB: begin x_s = a4 | b4;   y_s = a4 & ~b4;  end
            S_AMINUSBM1:   begin x_s = a4;        y_s = ~b4;       end
            S_ANBMINUS1:   begin x_s = a4 & ~b4;  y_s = 4'hF;      end
            S_APLUSAB:     begin x_s = a4;        y_s = a4 & b4;   end
            S_APLUSB:      begin x_s = a4;        y_s = b4;        end
            S_AORNBPLUSAB: begin x_s = a4 | ~b4;  y_s = a4 & b4;   end
            S_ABMINUS1:    begin x_s = a4 & b4;   y_s = 4'hF;      end
            S_APLUSA:      begin x_s = a4;        y_s = a4;        end
            S_AORBPLUSA:   begin x_s = a4 | b4;   y_s = a4;        end
            S_AORNBPLUSA:  begin x_s = a4 | ~b4;  y_s = a4;        end
            S_AMINUS1:     begin x_s = a4;        y_s = 4'hF;      end
            default:       begin x_s = a4;        y_s = 4'h0;      end
        endcase
    end

    // Logic-mode function table
    always_comb begin
        lf_s = 4'h0;
        case (s)
            4'd0:    lf_s = ~a4;
            4'd1:    lf_s = ~(a4 | b4);
            4'd2:    lf_s = ~a4 & b4;
            4'd3:    lf_s = 4'h0;
            4'd4:    lf_s = ~(a4 & b4);
            4'd5:    lf_s = ~b4;
            4'd6:    lf_s = a4 ^ b4;
            4'd7:    lf_s = a4 & ~b4;
            4'd8:    lf_s = ~a4 | b4;
            4'd9:    lf_s = ~(a4 ^ b4);
            4'd10:   lf_s = b4;
            4'd11:   lf_s = a4 & b4;
            4'd12:   lf_s = 4'hF;
            4'd13:   lf_s = a4 | ~b4;
            4'd14:   lf_s = a4 | b4;
            4'd15:   lf_s = a4;
            default: lf_s = 4'h0;
        endcase
    end

    // Adder, carries and propagate/generate; all carry outputs forced low in logic mode
    always_comb begin
        xy_s  = {1'b0, x_s} + {1'b0, y_s};
        sum_s = xy_s + {4'd0, c_in};
        low_s = {1'b0, x_s[2:0]} + {1'b0, y_s[2:0]} + {3'd0, c_in};
        if (m == M_ARITH) begin
            f4       = sum_s[3:0];
            c_out    = sum_s[4];
            c_msb_in = low_s[3];
            p        = (xy_s == 5'd15);
            g        = xy_s[4];
        end else begin
            f4       = lf_s;
            c_out    = 1'b0;
            c_msb_in = 1'b0;
            p        = 1'b0;
            g        = 1'b0;
        end
    end

endmodule

// File: rtl/alu_sliced_seq.sv
// Sequential bit-sliced ALU: one 4-bit slice per clock, LSB first, carry chained through a
// register; valid/ready on both sides, all outputs registered.
module alu_sliced_seq
    import alu_pkg::*;
#(
    parameter int SLICES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*SLICES-1:0]   a,
    input  logic [4*SLICES-1:0]   b,
    input  logic [3:0]            s,
    input  logic                  m,
    input  logic                  cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*SLICES-1:0]   f,
    output logic                  cout,
    output logic                  ovf,
    output logic                  aeqb,
    output logic                  zero,
    output logic                  grp_p,
    output logic                  grp_g
);

    localparam int WIDTH = 4 * SLICES;
    localparam int KW    = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(SLICES - 1);

    state_t           state_r;
    state_t           state_nx_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] f_r;
    logic [WIDTH-1:0] f_nx_s;
    logic [3:0]       s_r;
    logic             m_r;
    logic [KW-1:0]    k_r;
    logic             carry_r;
    logic             gacc_r;
    logic             pacc_r;
    logic             last_s;
    logic [3:0]       a4_s;
    logic [3:0]       b4_s;
    logic [3:0]       f4_s;
    logic             c_out_s;
    logic             c_msb_s;
    logic             p_s;
    logic             g_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             cout_r;
    logic             ovf_r;
    logic             aeqb_r;
    logic             zero_r;
    logic             grp_p_r;
    logic             grp_g_r;

    assign last_s    = (k_r == K_LAST);
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign f         = f_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;
    assign aeqb      = aeqb_r;
    assign zero      = zero_r;
    assign grp_p     = grp_p_r;
    assign grp_g     = grp_g_r;

    alu_slice4 u_slice (
        .a4       (a4_s),
        .b4       (b4_s),
        .s        (s_r),
        .m        (m_r),
        .c_in     (carry_r),
        .f4       (f4_s),
        .c_out    (c_out_s),
        .c_msb_in (c_msb_s),
        .p        (p_s),
        .g        (g_s)
    );

    // Operand nibble mux for the current slice index
    always_comb begin
        a4_s = 4'h0;
        b4_s = 4'h0;
        for (int i = 0; i < SLICES; i++) begin
            a4_s = (k_r == KW'(i)) ? a_r[i*4 +: 4] : a4_s;
            b4_s = (k_r == KW'(i)) ? b_r[i*4 +: 4] : b4_s;
        end
    end

    // Result word with the current slice's nibble merged in
    always_comb begin
        f_nx_s = f_r;
        for (int i = 0; i < SLICES; i++) begin
            f_nx_s[i*4 +: 4] = (k_r == KW'(i)) ? f4_s : f_r[i*4 +: 4];
        end
    end

    // FSM next-state
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Operand capture, slice accumulation and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r         <= '0;
            b_r         <= '0;
            s_r         <= 4'h0;
            m_r         <= 1'b0;
            k_r         <= '0;
            carry_r     <= 1'b0;
            gacc_r      <= 1'b0;
            pacc_r      <= 1'b0;
            f_r         <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            aeqb_r      <= 1'b0;
            zero_r      <= 1'b0;
            grp_p_r     <= 1'b0;
            grp_g_r     <= 1'b0;
        end else begin
            in_ready_r  <= (state_nx_s == IDLE);
            out_valid_r <= (state_nx_s == DONE);
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= a;
                        b_r     <= b;
                        s_r     <= s;
                        m_r     <= m;
                        k_r     <= '0;
                        carry_r <= (m == M_LOGIC) ? 1'b0 : cin;
                        gacc_r  <= 1'b0;
                        pacc_r  <= 1'b1;
                    end else begin
                        k_r     <= '0;
                    end
                end
                RUN: begin
                    f_r     <= f_nx_s;
                    carry_r <= c_out_s;
                    gacc_r  <= g_s | (p_s & gacc_r);
                    pacc_r  <= pacc_r & p_s;
                    k_r     <= k_r + KW'(1);
                    if (last_s) begin
                        cout_r  <= c_out_s;
                        ovf_r   <= c_msb_s ^ c_out_s;
                        aeqb_r  <= &f_nx_s;
                        zero_r  <= ~|f_nx_s;
                        grp_g_r <= g_s | (p_s & gacc_r);
                        grp_p_r <= pacc_r & p_s;
                    end else begin
                        ovf_r   <= ovf_r;
                    end
                end
                default: begin
                    k_r <= k_r;
                end
            endcase
        end
    end

endmodule
